// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-side bundle between pc_fetch_ctrl, the PC mux, instruction memory and decode.
// master = the fetch controller, slave = its environment (mux, imem, decode).
interface pc_fetch_ctrl_if;
  logic [31:0] pc_next;
  logic        stall;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] pc_out;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] instr;
  logic        instr_valid;
  logic        fetch_timeout;
  logic        fetch_fault;

  modport master (
    input  pc_next,
    input  stall,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata,
    output pc_out,
    output imem_req,
    output imem_addr,
    output instr,
    output instr_valid,
    output fetch_timeout,
    output fetch_fault
  );

  modport slave (
    output pc_next,
    output stall,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata,
    input  pc_out,
    input  imem_req,
    input  imem_addr,
    input  instr,
    input  instr_valid,
    input  fetch_timeout,
    input  fetch_fault
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// PC register and req/gnt/rvalid instruction-fetch sequencer with WAIT-state retry.
// Optional misaligned-target trap enabled by defining PC_FETCH_MISALIGN_CHECK_EN.
//
// state | meaning
// IDLE  | one cycle after reset, nothing outstanding
// REQ   | imem_req high, waiting for gnt (no timeout here)
// WAIT  | granted, waiting for rvalid; retries after TIMEOUT_CYCLES cycles
// VALID | instr presented to decode, held until !stall retires it
// FAULT | misaligned branch target trapped, held until rst (macro only)
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  pc_fetch_ctrl_if.master fetch_if
);

  localparam int unsigned      CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_VALID
`ifdef PC_FETCH_MISALIGN_CHECK_EN
    , S_FAULT
`endif
  } state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        // rvalid without gnt is stray and must not be captured
        if (fetch_if.imem_gnt) begin
          if (fetch_if.imem_rvalid) begin
            instr_d = fetch_if.imem_rdata;
            state_d = S_VALID;
          end else begin
            cnt_d   = '0;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (fetch_if.imem_rvalid) begin
          instr_d = fetch_if.imem_rdata;
          state_d = S_VALID;
        end else if (cnt_q == CNT_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_REQ;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_VALID: begin
        if (!fetch_if.stall) begin
          pc_d    = fetch_if.pc_next;
          state_d = S_REQ;
`ifdef PC_FETCH_MISALIGN_CHECK_EN
          if (fetch_if.pc_next[1:0] != 2'b00) begin
            state_d = S_FAULT;
          end
`endif
        end
      end
`ifdef PC_FETCH_MISALIGN_CHECK_EN
      S_FAULT: begin
        state_d = S_FAULT;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign fetch_if.pc_out        = pc_q;
  assign fetch_if.imem_addr     = {pc_q[31:2], 2'b00};
  assign fetch_if.imem_req      = (state_q == S_REQ);
  assign fetch_if.instr         = instr_q;
  assign fetch_if.instr_valid   = (state_q == S_VALID);
  assign fetch_if.fetch_timeout = timeout_q;
`ifdef PC_FETCH_MISALIGN_CHECK_EN
  assign fetch_if.fetch_fault   = (state_q == S_FAULT);
`else
  assign fetch_if.fetch_fault   = 1'b0;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios plus an instruction scoreboard
// that is filled when a response is driven and drained when instr_valid rises.
module tb_pc_fetch_ctrl;
  logic clk_i = 1'b0;
  logic rst_i;

  pc_fetch_ctrl_if fetch_if ();

  pc_fetch_ctrl #(
    .RESET_PC       (32'h0000_0000),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .fetch_if (fetch_if)
  );

  always #5 clk_i = ~clk_i;

  int          vec_cnt = 0;
  int          err_cnt = 0;
  logic [31:0] sb_q [$];

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  // scoreboard monitor: one instruction consumed per rising edge of instr_valid
  initial begin
    logic        prev_valid;
    logic [31:0] exp_instr;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk_i);
      if (fetch_if.instr_valid === 1'b1 && !prev_valid) begin
        vec_cnt++;
        if (sb_q.size() == 0) begin
          err_cnt++;
          $display("FAIL sb_unexpected: instr_valid with instr=%h, expected no instruction", fetch_if.instr);
        end else begin
          exp_instr = sb_q.pop_front();
          if (fetch_if.instr !== exp_instr) begin
            err_cnt++;
            $display("FAIL sb_instr: got %h expected %h", fetch_if.instr, exp_instr);
          end
        end
      end
      prev_valid = (fetch_if.instr_valid === 1'b1);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected run to complete");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst_i = 1'b1;
    fetch_if.imem_gnt    = 1'b1;
    fetch_if.imem_rvalid = 1'b0;
    fetch_if.imem_rdata  = 32'h0;
    fetch_if.stall       = 1'b0;
    fetch_if.pc_next     = 32'h0;
    for (int i = 0; i < 2; i++) begin
      tick();
      vec_cnt++;
      if (fetch_if.pc_out !== 32'h0 || fetch_if.instr !== 32'h0) begin
        err_cnt++;
        $display("FAIL reset_regs: pc_out=%h instr=%h expected 0/0", fetch_if.pc_out, fetch_if.instr);
      end
      vec_cnt++;
      if ({fetch_if.imem_req, fetch_if.instr_valid, fetch_if.fetch_timeout, fetch_if.fetch_fault} !== 4'b0000) begin
        err_cnt++;
        $display("FAIL reset_flags: req/valid/timeout/fault=%b expected 0000",
                 {fetch_if.imem_req, fetch_if.instr_valid, fetch_if.fetch_timeout, fetch_if.fetch_fault});
      end
    end
    rst_i = 1'b0;
    #1;
    vec_cnt++;
    if (fetch_if.imem_req !== 1'b0) begin
      err_cnt++;
      $display("FAIL idle_req: got %b expected 0", fetch_if.imem_req);
    end
    tick();
    vec_cnt++;
    if (fetch_if.imem_req !== 1'b1 || fetch_if.imem_addr !== 32'h0) begin
      err_cnt++;
      $display("FAIL first_req: req=%b addr=%h expected 1/00000000", fetch_if.imem_req, fetch_if.imem_addr);
    end
  endtask

  task automatic test_zero_wait();
    logic [31:0] exp_pc;
    do_reset();
    fetch_if.imem_gnt    = 1'b1;
    fetch_if.imem_rvalid = 1'b1;
    fetch_if.imem_rdata  = 32'h0050_0093;
    fetch_if.stall       = 1'b0;
    fetch_if.pc_next     = 32'h4;
    tick();
    sb_q.push_back(32'h0050_0093);
    tick();
    vec_cnt++;
    if (fetch_if.instr_valid !== 1'b1 || fetch_if.instr !== 32'h0050_0093 || fetch_if.pc_out !== 32'h0) begin
      err_cnt++;
      $display("FAIL zw_valid: valid=%b instr=%h pc=%h expected 1/00500093/00000000",
               fetch_if.instr_valid, fetch_if.instr, fetch_if.pc_out);
    end
    tick();
    vec_cnt++;
    if (fetch_if.pc_out !== 32'h4 || fetch_if.imem_addr !== 32'h4 || fetch_if.imem_req !== 1'b1) begin
      err_cnt++;
      $display("FAIL zw_retire: pc=%h addr=%h req=%b expected 4/4/1",
               fetch_if.pc_out, fetch_if.imem_addr, fetch_if.imem_req);
    end
    exp_pc = 32'h4;
    for (int i = 0; i < 4; i++) begin
      fetch_if.imem_rdata = 32'h1000_0013 + 32'(i);
      fetch_if.pc_next    = exp_pc + 32'h4;
      sb_q.push_back(32'h1000_0013 + 32'(i));
      tick();
      vec_cnt++;
      if (fetch_if.instr_valid !== 1'b1) begin
        err_cnt++;
        $display("FAIL b2b_valid[%0d]: got %b expected 1", i, fetch_if.instr_valid);
      end
      tick();
      exp_pc = exp_pc + 32'h4;
      vec_cnt++;
      if (fetch_if.pc_out !== exp_pc || fetch_if.imem_req !== 1'b1) begin
        err_cnt++;
        $display("FAIL b2b_pc[%0d]: pc=%h req=%b expected %h/1", i, fetch_if.pc_out, fetch_if.imem_req, exp_pc);
      end
    end
    fetch_if.imem_rvalid = 1'b0;
    fetch_if.imem_gnt    = 1'b0;
  endtask

  task automatic test_stall();
    do_reset();
    fetch_if.imem_gnt    = 1'b1;
    fetch_if.imem_rvalid = 1'b1;
    fetch_if.imem_rdata  = 32'h00a0_0113;
    fetch_if.stall       = 1'b1;
    fetch_if.pc_next     = 32'h8;
    tick();
    sb_q.push_back(32'h00a0_0113);
    tick();
    for (int k = 0; k < 3; k++) begin
      fetch_if.pc_next    = (k == 1) ? 32'h40 : 32'h8;
      fetch_if.imem_rdata = 32'hdead_beef;
      tick();
      vec_cnt++;
      if (fetch_if.instr_valid !== 1'b1 || fetch_if.instr !== 32'h00a0_0113 || fetch_if.pc_out !== 32'h0) begin
        err_cnt++;
        $display("FAIL stall_hold[%0d]: valid=%b instr=%h pc=%h expected 1/00a00113/00000000",
                 k, fetch_if.instr_valid, fetch_if.instr, fetch_if.pc_out);
      end
    end
    fetch_if.stall       = 1'b0;
    fetch_if.pc_next     = 32'h40;
    fetch_if.imem_rvalid = 1'b0;
    tick();
    vec_cnt++;
    if (fetch_if.pc_out !== 32'h40 || fetch_if.imem_req !== 1'b1 || fetch_if.instr_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL stall_release: pc=%h req=%b valid=%b expected 00000040/1/0",
               fetch_if.pc_out, fetch_if.imem_req, fetch_if.instr_valid);
    end
    fetch_if.imem_gnt = 1'b0;
  endtask

  task automatic test_timeout();
    int bad;
    int pulses;
    int reqs;
    do_reset();
    fetch_if.imem_gnt    = 1'b1;
    fetch_if.imem_rvalid = 1'b1;
    fetch_if.imem_rdata  = 32'h0020_0213;
    fetch_if.stall       = 1'b0;
    fetch_if.pc_next     = 32'h20;
    tick();
    sb_q.push_back(32'h0020_0213);
    tick();
    tick();
    fetch_if.imem_rvalid = 1'b0;
    fetch_if.imem_gnt    = 1'b0;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (fetch_if.imem_req !== 1'b1 || fetch_if.fetch_timeout !== 1'b0 || fetch_if.imem_addr !== 32'h20) bad++;
    end
    vec_cnt++;
    if (bad != 0) begin
      err_cnt++;
      $display("FAIL req_no_timeout: %0d bad cycles holding REQ without gnt, expected 0", bad);
    end
    fetch_if.imem_gnt = 1'b1;
    tick();
    vec_cnt++;
    if (fetch_if.imem_req !== 1'b0 || fetch_if.fetch_timeout !== 1'b0) begin
      err_cnt++;
      $display("FAIL wait_entry: req=%b timeout=%b expected 0/0", fetch_if.imem_req, fetch_if.fetch_timeout);
    end
    for (int r = 0; r < 2; r++) begin
      pulses = 0;
      reqs   = 0;
      for (int i = 0; i < 15; i++) begin
        tick();
        pulses += int'(fetch_if.fetch_timeout === 1'b1);
        reqs   += int'(fetch_if.imem_req === 1'b1);
      end
      vec_cnt++;
      if (pulses != 0 || reqs != 0) begin
        err_cnt++;
        $display("FAIL early_retry[%0d]: pulses=%0d reqs=%0d expected 0/0", r, pulses, reqs);
      end
      tick();
      vec_cnt++;
      if (fetch_if.imem_req !== 1'b1 || fetch_if.fetch_timeout !== 1'b1 || fetch_if.imem_addr !== 32'h20) begin
        err_cnt++;
        $display("FAIL retry[%0d]: req=%b timeout=%b addr=%h expected 1/1/00000020",
                 r, fetch_if.imem_req, fetch_if.fetch_timeout, fetch_if.imem_addr);
      end
      tick();
      vec_cnt++;
      if (fetch_if.fetch_timeout !== 1'b0 || fetch_if.imem_req !== 1'b0) begin
        err_cnt++;
        $display("FAIL pulse_width[%0d]: timeout=%b req=%b expected 0/0", r, fetch_if.fetch_timeout, fetch_if.imem_req);
      end
    end
    fetch_if.imem_rvalid = 1'b1;
    fetch_if.imem_rdata  = 32'h0030_0313;
    sb_q.push_back(32'h0030_0313);
    tick();
    vec_cnt++;
    if (fetch_if.instr_valid !== 1'b1 || fetch_if.instr !== 32'h0030_0313) begin
      err_cnt++;
      $display("FAIL wait_rvalid: valid=%b instr=%h expected 1/00300313", fetch_if.instr_valid, fetch_if.instr);
    end
    fetch_if.imem_rvalid = 1'b0;
    fetch_if.imem_gnt    = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    fetch_if.imem_gnt    = 1'b1;
    fetch_if.imem_rvalid = 1'b1;
    fetch_if.imem_rdata  = 32'h0040_0413;
    fetch_if.stall       = 1'b0;
    fetch_if.pc_next     = 32'h40;
    tick();
    sb_q.push_back(32'h0040_0413);
    tick();
    tick();
    fetch_if.imem_rvalid = 1'b0;
    tick();
    vec_cnt++;
    if (fetch_if.imem_req !== 1'b0 || fetch_if.pc_out !== 32'h40) begin
      err_cnt++;
      $display("FAIL mid_wait: req=%b pc=%h expected 0/00000040", fetch_if.imem_req, fetch_if.pc_out);
    end
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    fetch_if.imem_rvalid = 1'b1;
    fetch_if.imem_rdata  = 32'hbad0_bad0;
    fetch_if.imem_gnt    = 1'b0;
    #1;
    vec_cnt++;
    if (fetch_if.pc_out !== 32'h0 || fetch_if.instr !== 32'h0 || fetch_if.instr_valid !== 1'b0 ||
        fetch_if.imem_req !== 1'b0) begin
      err_cnt++;
      $display("FAIL mid_reset: pc=%h instr=%h valid=%b req=%b expected 0/0/0/0",
               fetch_if.pc_out, fetch_if.instr, fetch_if.instr_valid, fetch_if.imem_req);
    end
    tick();
    vec_cnt++;
    if (fetch_if.imem_req !== 1'b1 || fetch_if.instr_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL idle_stray: req=%b valid=%b expected 1/0", fetch_if.imem_req, fetch_if.instr_valid);
    end
    tick();
    vec_cnt++;
    if (fetch_if.imem_req !== 1'b1 || fetch_if.instr_valid !== 1'b0 || fetch_if.instr !== 32'h0) begin
      err_cnt++;
      $display("FAIL req_stray: req=%b valid=%b instr=%h expected 1/0/00000000",
               fetch_if.imem_req, fetch_if.instr_valid, fetch_if.instr);
    end
    fetch_if.imem_rvalid = 1'b0;
  endtask

  task automatic test_misalign();
    do_reset();
    fetch_if.imem_gnt    = 1'b1;
    fetch_if.imem_rvalid = 1'b1;
    fetch_if.imem_rdata  = 32'h0050_0513;
    fetch_if.stall       = 1'b0;
    fetch_if.pc_next     = 32'h102;
    tick();
    sb_q.push_back(32'h0050_0513);
    tick();
    tick();
`ifdef PC_FETCH_MISALIGN_CHECK_EN
    begin
      int bad;
      vec_cnt++;
      if (fetch_if.fetch_fault !== 1'b1 || fetch_if.imem_req !== 1'b0 || fetch_if.pc_out !== 32'h102) begin
        err_cnt++;
        $display("FAIL fault_entry: fault=%b req=%b pc=%h expected 1/0/00000102",
                 fetch_if.fetch_fault, fetch_if.imem_req, fetch_if.pc_out);
      end
      bad = 0;
      for (int i = 0; i < 6; i++) begin
        tick();
        if (fetch_if.fetch_fault !== 1'b1 || fetch_if.imem_req !== 1'b0 || fetch_if.instr_valid !== 1'b0) bad++;
      end
      vec_cnt++;
      if (bad != 0) begin
        err_cnt++;
        $display("FAIL fault_hold: %0d bad cycles, expected 0", bad);
      end
      fetch_if.imem_rvalid = 1'b0;
      do_reset();
      vec_cnt++;
      if (fetch_if.fetch_fault !== 1'b0 || fetch_if.pc_out !== 32'h0) begin
        err_cnt++;
        $display("FAIL fault_clear: fault=%b pc=%h expected 0/00000000", fetch_if.fetch_fault, fetch_if.pc_out);
      end
    end
`else
    vec_cnt++;
    if (fetch_if.pc_out !== 32'h102 || fetch_if.imem_addr !== 32'h100 || fetch_if.fetch_fault !== 1'b0 ||
        fetch_if.imem_req !== 1'b1) begin
      err_cnt++;
      $display("FAIL misalign_off: pc=%h addr=%h fault=%b req=%b expected 00000102/00000100/0/1",
               fetch_if.pc_out, fetch_if.imem_addr, fetch_if.fetch_fault, fetch_if.imem_req);
    end
    fetch_if.imem_rvalid = 1'b0;
    fetch_if.imem_gnt    = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_stall();
    test_timeout();
    test_reset_mid();
    test_misalign();
    tick();
    tick();
    vec_cnt++;
    if (sb_q.size() != 0) begin
      err_cnt++;
      $display("FAIL sb_drain: %0d instructions never presented, expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
